// File: rtl/fetch_queue.sv
// fetch_queue: instruction/PC buffer between fetch and decode.
//   Fetch pushes {instr, pc} pairs while decode may stall; an execute-side
//   flush drops every buffered entry. A saturating counter records cycles in
//   which decode was ready but the queue had nothing to give it.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   push_valid_i/instr/pc    fetch side; push_ready_o = not full
//   pop_valid_o/instr/pc     decode side head (NOP_INSTR / 0 when empty)
//   pop_ready_i              decode consumes the head this cycle
//   flush_i                  discard all entries (branch redirect)
//   count_o                  occupancy 0..DEPTH
//   starve_cnt_o             saturating decode-starvation cycle count
module fetch_queue #(
    parameter int              DEPTH      = 4,
    parameter int              DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid_i,
    input  logic [DATA_WIDTH-1:0]      push_instr_i,
    input  logic [DATA_WIDTH-1:0]      push_pc_i,
    output logic                       push_ready_o,
    output logic                       pop_valid_o,
    output logic [DATA_WIDTH-1:0]      pop_instr_o,
    output logic [DATA_WIDTH-1:0]      pop_pc_o,
    input  logic                       pop_ready_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [31:0]                starve_cnt_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0] pc;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        starve_q, starve_d;

    logic push_fire, pop_fire;

    // Ready/valid come from registered occupancy only; a full queue refuses
    // a push even if decode pops in the same cycle.
    assign push_ready_o = (count_q != CNT_W'(DEPTH));
    assign pop_valid_o  = (count_q != '0);
    assign pop_instr_o  = pop_valid_o ? mem_q[rd_ptr_q].instr : NOP_INSTR;
    assign pop_pc_o     = pop_valid_o ? mem_q[rd_ptr_q].pc    : '0;
    assign count_o      = count_q;
    assign starve_cnt_o = starve_q;

    assign push_fire = push_valid_i & push_ready_o;
    assign pop_fire  = pop_ready_i & pop_valid_o;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;

        // Starvation is sampled on the pre-edge state; a flush cycle is
        // excluded, and the counter survives flushes.
        if (pop_ready_i && !pop_valid_o && !flush_i && (starve_q != '1))
            starve_d = starve_q + 32'd1;

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_fire) begin
                mem_d[wr_ptr_q] = '{instr: push_instr_i, pc: push_pc_i};
                wr_ptr_d        = wr_ptr_q + 1'b1;  // power-of-two wrap
            end
            if (pop_fire)
                rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    // Storage needs no reset: it is only read when count says it is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid_i;
    logic [31:0] push_instr_i;
    logic [31:0] push_pc_i;
    logic        push_ready_o;
    logic        pop_valid_o;
    logic [31:0] pop_instr_o;
    logic [31:0] pop_pc_o;
    logic        pop_ready_i;
    logic        flush_i;
    logic [2:0]  count_o;
    logic [31:0] starve_cnt_o;

    int total = 0;
    int bad   = 0;

    fetch_queue #(.DEPTH(4), .DATA_WIDTH(32), .NOP_INSTR(32'h0000_0013)) dut (
        .clk(clk), .rst(rst),
        .push_valid_i(push_valid_i), .push_instr_i(push_instr_i), .push_pc_i(push_pc_i),
        .push_ready_o(push_ready_o),
        .pop_valid_o(pop_valid_o), .pop_instr_o(pop_instr_o), .pop_pc_o(pop_pc_o),
        .pop_ready_i(pop_ready_i), .flush_i(flush_i),
        .count_o(count_o), .starve_cnt_o(starve_cnt_o)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        push_valid_i = 0; push_instr_i = '0; push_pc_i = '0;
        pop_ready_i = 0; flush_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (push_ready_o !== 1'b1) begin bad++; $display("FAIL reset_push_ready got=%0b exp=1", push_ready_o); end
        total++; if (pop_valid_o !== 1'b0) begin bad++; $display("FAIL reset_pop_valid got=%0b exp=0", pop_valid_o); end
        total++; if (pop_instr_o !== 32'h13) begin bad++; $display("FAIL reset_pop_instr got=%h exp=00000013", pop_instr_o); end
        total++; if (pop_pc_o !== 32'h0) begin bad++; $display("FAIL reset_pop_pc got=%h exp=0", pop_pc_o); end
        total++; if (count_o !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        total++; if (starve_cnt_o !== 32'd0) begin bad++; $display("FAIL reset_starve got=%0d exp=0", starve_cnt_o); end
    endtask

    task automatic test_ordered();
        logic [31:0] pcs [3];
        logic [31:0] ins [3];
        pcs = '{32'h0, 32'h4, 32'h8};
        ins = '{32'hA, 32'hB, 32'hC};
        do_reset();
        pop_ready_i = 1;
        for (int i = 0; i < 3; i++) begin
            push_valid_i = 1; push_pc_i = pcs[i]; push_instr_i = ins[i];
            if (i == 0) begin
                #1;  // no same-cycle bypass while empty
                total++; if (pop_valid_o !== 1'b0) begin bad++; $display("FAIL ordered_no_bypass got=%0b exp=0", pop_valid_o); end
            end
            tick();
            total++; if (pop_pc_o !== pcs[i] || pop_instr_o !== ins[i])
                begin bad++; $display("FAIL ordered_head%0d got=%h/%h exp=%h/%h", i, pop_pc_o, pop_instr_o, pcs[i], ins[i]); end
            total++; if (count_o !== 3'd1) begin bad++; $display("FAIL ordered_count%0d got=%0d exp=1", i, count_o); end
        end
        push_valid_i = 0;
        tick();
        total++; if (pop_valid_o !== 1'b0) begin bad++; $display("FAIL ordered_drained got=%0b exp=0", pop_valid_o); end
        idle_inputs();
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_valid_i = 1; push_pc_i = 32'h100 + 32'(4 * i); push_instr_i = 32'h1000 + 32'(i);
            #1;
            total++; if (push_ready_o !== (i < 4))
                begin bad++; $display("FAIL fill_ready%0d got=%0b exp=%0b", i, push_ready_o, (i < 4)); end
            tick();
        end
        push_valid_i = 0;
        total++; if (count_o !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", count_o); end
        total++; if (pop_pc_o !== 32'h100 || pop_instr_o !== 32'h1000)
            begin bad++; $display("FAIL fill_head got=%h/%h exp=00000100/00001000", pop_pc_o, pop_instr_o); end
        // full queue refuses a push even with a simultaneous pop
        push_valid_i = 1; push_pc_i = 32'hDEAD; pop_ready_i = 1;
        tick();
        total++; if (count_o !== 3'd3) begin bad++; $display("FAIL fill_full_pop count got=%0d exp=3", count_o); end
        idle_inputs();
    endtask

    task automatic test_wrap();
        int h = 0;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            push_valid_i = 1; push_pc_i = 32'h200 + 32'(4 * k); push_instr_i = 32'h2000 + 32'(k);
            tick();
        end
        pop_ready_i = 1;
        for (int k = 2; k < 12; k++) begin
            push_valid_i = 1; push_pc_i = 32'h200 + 32'(4 * k); push_instr_i = 32'h2000 + 32'(k);
            #1;
            total++; if (pop_pc_o !== 32'h200 + 32'(4 * h))
                begin bad++; $display("FAIL wrap_order%0d got=%h exp=%h", h, pop_pc_o, 32'h200 + 32'(4 * h)); end
            tick();
            h++;
            total++; if (count_o !== 3'd2) begin bad++; $display("FAIL wrap_count%0d got=%0d exp=2", k, count_o); end
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            push_valid_i = 1; push_pc_i = 32'h300 + 32'(4 * k); push_instr_i = 32'h3000 + 32'(k);
            tick();
        end
        total++; if (count_o !== 3'd3) begin bad++; $display("FAIL flush_pre_count got=%0d exp=3", count_o); end
        flush_i = 1; push_valid_i = 1; push_pc_i = 32'h3FC; push_instr_i = 32'h3FFF; pop_ready_i = 1;
        tick();
        total++; if (count_o !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count_o); end
        total++; if (pop_valid_o !== 1'b0) begin bad++; $display("FAIL flush_pop_valid got=%0b exp=0", pop_valid_o); end
        total++; if (push_ready_o !== 1'b1) begin bad++; $display("FAIL flush_push_ready got=%0b exp=1", push_ready_o); end
        total++; if (starve_cnt_o !== 32'd0) begin bad++; $display("FAIL flush_starve got=%0d exp=0", starve_cnt_o); end
        flush_i = 0; pop_ready_i = 0; push_pc_i = 32'h400; push_instr_i = 32'h4000;
        tick();
        total++; if (pop_valid_o !== 1'b1 || pop_pc_o !== 32'h400 || count_o !== 3'd1)
            begin bad++; $display("FAIL flush_post_push got=%0b/%h/%0d exp=1/00000400/1", pop_valid_o, pop_pc_o, count_o); end
        push_valid_i = 0; pop_ready_i = 1;
        tick();
        // empty, decode ready, flush asserted: not a starvation cycle
        flush_i = 1;
        tick();
        total++; if (starve_cnt_o !== 32'd0) begin bad++; $display("FAIL flush_empty_starve got=%0d exp=0", starve_cnt_o); end
        idle_inputs();
        // reset mid-operation discards entries and clears the counter
        push_valid_i = 1; push_pc_i = 32'h500;
        tick();
        pop_ready_i = 0; push_valid_i = 0;
        rst = 1;
        tick();
        rst = 0;
        total++; if (count_o !== 3'd0 || pop_valid_o !== 1'b0)
            begin bad++; $display("FAIL midrst got=%0d/%0b exp=0/0", count_o, pop_valid_o); end
    endtask

    task automatic test_starve();
        do_reset();
        pop_ready_i = 1;
        for (int i = 0; i < 7; i++) tick();
        total++; if (starve_cnt_o !== 32'd7) begin bad++; $display("FAIL starve7 got=%0d exp=7", starve_cnt_o); end
        force dut.starve_q = 32'hFFFF_FFFE;
        #1;
        release dut.starve_q;
        tick();
        total++; if (starve_cnt_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL starve_max got=%h exp=ffffffff", starve_cnt_o); end
        tick();
        tick();
        total++; if (starve_cnt_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL starve_sat got=%h exp=ffffffff", starve_cnt_o); end
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_ordered();
        test_fill();
        test_wrap();
        test_flush();
        test_starve();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the fetch stage and the decode stage. It buffers fetched instruction/PC pairs so fetch keeps running while decode is stalled, and drops all buffered entries on a branch-redirect flush from execute. It also keeps a saturating count of decode-starvation cycles for performance analysis.

## Interface
- DEPTH, 4: number of entries; power of two, minimum 2.
- DATA_WIDTH, 32: instruction and PC width.
- NOP_INSTR, 32'h0000_0013: bubble value (addi x0,x0,0) driven on pop_instr_o when empty.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- push_valid_i  in  1  fetch presents a valid instruction.
- push_instr_i  in  DATA_WIDTH  fetched instruction word.
- push_pc_i  in  DATA_WIDTH  PC of push_instr_i.
- push_ready_o  out  1  queue can accept a push this cycle.
- pop_valid_o  out  1  head entry valid.
- pop_instr_o  out  DATA_WIDTH  head instruction, NOP_INSTR when empty.
- pop_pc_o  out  DATA_WIDTH  head PC, 0 when empty.
- pop_ready_i  in  1  decode consumes the head this cycle (low while decode stalls).
- flush_i  in  1  pipeline flush from execute (branch taken / redirect).
- count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- starve_cnt_o  out  32  saturating count of cycles with pop_ready_i=1 and pop_valid_o=0.

## Operation
- Storage: DEPTH-entry array of {instr, pc}; read pointer, write pointer, each $clog2(DEPTH) bits, wrap modulo DEPTH; separate occupancy counter.
- push_ready_o = (count_o != DEPTH). Registered state only; it does not look at pop_ready_i, so a full queue refuses a push even when a pop happens in the same cycle.
- pop_valid_o = (count_o != 0). pop_instr_o/pop_pc_o are a combinational read of the entry at the read pointer when valid, else NOP_INSTR/0.
- Push fires when push_valid_i & push_ready_o: write the entry at the write pointer, then increment the write pointer.
- Pop fires when pop_ready_i & pop_valid_o: increment the read pointer.
- Count update: +1 on push only, -1 on pop only, unchanged when both fire.
- Flush (priority over everything except rst):
  - both pointers and the count go to 0;
  - any push in the same cycle is dropped, and so is any pop;
  - storage contents are don't-care.
- starve_cnt_o:
  - increments by 1 in any cycle with pop_ready_i=1, pop_valid_o=0 and flush_i=0;
  - holds at 32'hFFFF_FFFF once reached;
  - is not cleared by flush, only by rst.
- Reset:
  - pointers and count become 0, starve_cnt_o becomes 0;
  - outputs after reset: push_ready_o=1, pop_valid_o=0, pop_instr_o=NOP_INSTR, pop_pc_o=0, count_o=0.
  - rst mid-operation discards all entries in that cycle, with the same result as flush plus the counter clear.

## Timing
- Push-to-pop latency is 1 cycle: an entry pushed at edge N is visible on pop_* after edge N, with no same-cycle bypass when empty.
- Pop-to-next-head is 0 extra cycles: the next entry is on pop_* right after the consuming edge.
- Full-queue throughput is 1 push and 1 pop per cycle whenever 0 < count < DEPTH.
- With DEPTH=4, a stalled decode plus continuous fetch deasserts push_ready_o after 4 accepted pushes.
- Flush asserted at edge N: pop_valid_o=0 and push_ready_o=1 after edge N; the first post-flush push is poppable after edge N+1.
- Pointer wrap: after DEPTH pushes the write pointer returns to 0, and FIFO order is preserved across the wrap.

## Test plan
- Reset then idle: hold rst=1 for 2 cycles, release → push_ready_o=1, pop_valid_o=0, pop_instr_o=32'h00000013, count_o=0, starve_cnt_o=0.
- Ordered flow: push PCs 0x0,0x4,0x8 with instrs 0xA,0xB,0xC while pop_ready_i=1 → pop sequence 0x0/0xA, 0x4/0xB, 0x8/0xC, each 1 cycle after its push.
- Fill with stalled decode: pop_ready_i=0, push 5 consecutive cycles → first 4 accepted, push_ready_o=0 on the 5th, count_o=4.
- Wrap-around under simultaneous push+pop: hold count at 2 and push/pop every cycle for 10 cycles → count_o stays 2, PCs emerge strictly in order.
- Flush priority: count=3, assert flush_i together with push_valid_i=1 and pop_ready_i=1 → after the edge count_o=0, pop_valid_o=0, the pushed entry is absent, and starve_cnt_o is unchanged by that cycle.
- Starvation counter: empty queue with pop_ready_i=1 for 7 cycles → starve_cnt_o=7; force the counter to 32'hFFFFFFFE and starve 3 more cycles → reads 32'hFFFFFFFF.
